// File: rtl/pc_fetch_unit_pkg.sv
// Shared fetch-stage types and parameter defaults for pc_fetch_unit and its next-PC mux.
// Pure declarations: no logic, no latency, no backpressure.
package pc_fetch_unit_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } fetch_state_e;

    localparam int unsigned DEF_XLEN         = 32;
    localparam logic [31:0] DEF_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEF_TRAP_VECTOR  = 32'h0000_0100;
    localparam int unsigned DEF_ILEN_BYTES   = 4;

endpackage

// File: rtl/pc_fetch_unit_pc_next_mux.sv
// Combinational next-PC select (trap > branch > sequential > hold) with misaligned-target check.
// Zero latency; redirects ignore StallF and imem_ready, and nothing is selected while in BOOT.
module pc_next_mux
    import pc_fetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN        = DEF_XLEN,
    parameter logic [XLEN-1:0] TRAP_VECTOR = DEF_TRAP_VECTOR,
    parameter int unsigned     ILEN_BYTES  = DEF_ILEN_BYTES
) (
    input  logic [XLEN-1:0] pc_i,
    input  fetch_state_e    state_i,
    input  logic            trap_i,
    input  logic            branch_i,
    input  logic [XLEN-1:0] target_i,
    input  logic            accept_i,
    output logic [XLEN-1:0] pc_plus_o,
    output logic [XLEN-1:0] pc_next_o,
    output logic            redirect_o,
    output logic            misalign_o
);

    localparam logic [XLEN-1:0] ILEN_INC   = XLEN'(ILEN_BYTES);
    localparam logic [XLEN-1:0] ALIGN_MASK = XLEN'(ILEN_BYTES - 1);

    logic target_misaligned;

    assign pc_plus_o         = pc_i + ILEN_INC;
    assign target_misaligned = |(target_i & ALIGN_MASK);

    always_comb begin
        pc_next_o  = pc_i;
        redirect_o = 1'b0;
        misalign_o = 1'b0;
        if (state_i != ST_BOOT) begin
            redirect_o = trap_i | branch_i;
            if (trap_i) begin
                pc_next_o = TRAP_VECTOR;
            end else if (branch_i) begin
                // A misaligned target is never fetched; it is turned into a trap redirect.
                if (target_misaligned) begin
                    pc_next_o  = TRAP_VECTOR;
                    misalign_o = 1'b1;
                end else begin
                    pc_next_o = target_i;
                end
            end else if (accept_i) begin
                pc_next_o = pc_plus_o;
            end
        end
    end

endmodule

// File: rtl/pc_fetch_unit.sv
// Fetch-stage PC: BOOT/RUN/HALT control, PC register, misalign capture and accepted-fetch counter.
// PC/imem_req update one edge after inputs; holds on StallF or !imem_ready, redirects override both.
module pc_fetch_unit
    import pc_fetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN         = DEF_XLEN,
    parameter logic [XLEN-1:0] RESET_VECTOR = DEF_RESET_VECTOR,
    parameter logic [XLEN-1:0] TRAP_VECTOR  = DEF_TRAP_VECTOR,
    parameter int unsigned     ILEN_BYTES   = DEF_ILEN_BYTES
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            StallF,
    input  logic            BranchTakenE,
    input  logic [XLEN-1:0] BranchTargetE,
    input  logic            TrapReq,
    input  logic            Halt,
    input  logic            Resume,
    input  logic            imem_ready,
    output logic            imem_req,
    output logic [XLEN-1:0] PC,
    output logic [XLEN-1:0] PCPlus4F,
    output logic            FlushD,
    output logic            MisalignF,
    output logic [XLEN-1:0] BadAddr,
    output logic [XLEN-1:0] FetchCount
);

    localparam logic [XLEN-1:0] CNT_ONE = XLEN'(1);

    fetch_state_e    state_q;
    logic            imem_req_q;
    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] pc_plus;
    logic            misalign_q, misalign_d;
    logic [XLEN-1:0] bad_addr_q, bad_addr_d;
    logic [XLEN-1:0] fetch_cnt_q, fetch_cnt_d;
    logic            accept;
    logic            redirect;

    assign accept = imem_req_q & imem_ready & ~StallF;

    pc_next_mux #(
        .XLEN        (XLEN),
        .TRAP_VECTOR (TRAP_VECTOR),
        .ILEN_BYTES  (ILEN_BYTES)
    ) u_pc_next_mux (
        .pc_i       (pc_q),
        .state_i    (state_q),
        .trap_i     (TrapReq),
        .branch_i   (BranchTakenE),
        .target_i   (BranchTargetE),
        .accept_i   (accept),
        .pc_plus_o  (pc_plus),
        .pc_next_o  (pc_d),
        .redirect_o (redirect),
        .misalign_o (misalign_d)
    );

    // A redirect abandons the in-flight request, so it never counts as a fetch.
    always_comb begin
        bad_addr_d  = misalign_d ? BranchTargetE : bad_addr_q;
        fetch_cnt_d = (accept && !redirect) ? fetch_cnt_q + CNT_ONE : fetch_cnt_q;
    end

    // Trap always lands in RUN; a branch leaves HALT/RUN selection to Halt/Resume.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_BOOT;
            imem_req_q <= 1'b0;
        end else begin
            case (state_q)
                ST_BOOT: begin
                    state_q    <= ST_RUN;
                    imem_req_q <= 1'b1;
                end
                ST_RUN: begin
                    if (Halt && !TrapReq) begin
                        state_q    <= ST_HALT;
                        imem_req_q <= 1'b0;
                    end
                end
                ST_HALT: begin
                    if (Resume || TrapReq) begin
                        state_q    <= ST_RUN;
                        imem_req_q <= 1'b1;
                    end
                end
                default: begin
                    state_q    <= ST_BOOT;
                    imem_req_q <= 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q        <= RESET_VECTOR;
            misalign_q  <= 1'b0;
            bad_addr_q  <= '0;
            fetch_cnt_q <= '0;
        end else begin
            pc_q        <= pc_d;
            misalign_q  <= misalign_d;
            bad_addr_q  <= bad_addr_d;
            fetch_cnt_q <= fetch_cnt_d;
        end
    end

    assign imem_req   = imem_req_q;
    assign PC         = pc_q;
    assign PCPlus4F   = pc_plus;
    assign FlushD     = redirect;
    assign MisalignF  = misalign_q;
    assign BadAddr    = bad_addr_q;
    assign FetchCount = fetch_cnt_q;

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed literal checks, then randomized traffic against a behavioural model.
module tb_pc_fetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        StallF, BranchTakenE, TrapReq, Halt, Resume, imem_ready;
    logic [31:0] BranchTargetE;
    logic        imem_req, FlushD, MisalignF;
    logic [31:0] PC, PCPlus4F, BadAddr, FetchCount;

    int tests = 0;
    int fails = 0;

    localparam int M_BOOT = 0;
    localparam int M_RUN  = 1;
    localparam int M_HALT = 2;

    // Reference model state
    int          m_st;
    logic [31:0] m_pc, m_bad, m_cnt;
    logic        m_mis;
    bit          m_ok = 1'b0;

    always #5 clk = ~clk;

    pc_fetch_unit dut (
        .clk           (clk),
        .rst           (rst),
        .StallF        (StallF),
        .BranchTakenE  (BranchTakenE),
        .BranchTargetE (BranchTargetE),
        .TrapReq       (TrapReq),
        .Halt          (Halt),
        .Resume        (Resume),
        .imem_ready    (imem_ready),
        .imem_req      (imem_req),
        .PC            (PC),
        .PCPlus4F      (PCPlus4F),
        .FlushD        (FlushD),
        .MisalignF     (MisalignF),
        .BadAddr       (BadAddr),
        .FetchCount    (FetchCount)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // One clock edge of the architectural rules, evaluated on the inputs seen at that edge.
    task automatic model_update();
        logic mis_next;
        mis_next = 1'b0;
        if (rst) begin
            m_st  = M_BOOT;
            m_pc  = 32'h0;
            m_bad = 32'h0;
            m_cnt = 32'h0;
            m_ok  = 1'b1;
        end else if (m_st == M_BOOT) begin
            m_st = M_RUN;
        end else begin
            if (TrapReq) begin
                m_pc = 32'h100;
                m_st = M_RUN;
            end else begin
                if (BranchTakenE) begin
                    if ((BranchTargetE % 4) != 0) begin
                        m_pc     = 32'h100;
                        m_bad    = BranchTargetE;
                        mis_next = 1'b1;
                    end else begin
                        m_pc = BranchTargetE;
                    end
                end else if (m_st == M_RUN && imem_ready && !StallF) begin
                    m_pc  = m_pc + 32'd4;
                    m_cnt = m_cnt + 32'd1;
                end
                if (m_st == M_RUN && Halt)
                    m_st = M_HALT;
                else if (m_st == M_HALT && Resume)
                    m_st = M_RUN;
            end
        end
        m_mis = mis_next;
    endtask

    // Compare at the falling edge, then advance the model on the rising edge.
    task automatic cycle();
        @(negedge clk);
        if (m_ok) begin
            chk("PC", PC, m_pc);
            chk("PCPlus4F", PCPlus4F, m_pc + 32'd4);
            chk("imem_req", imem_req, m_st == M_RUN);
            chk("FlushD", FlushD, (m_st != M_BOOT) && (TrapReq || BranchTakenE));
            chk("MisalignF", MisalignF, m_mis);
            chk("BadAddr", BadAddr, m_bad);
            chk("FetchCount", FetchCount, m_cnt);
        end
        @(posedge clk);
        model_update();
        #1;
    endtask

    initial begin
        rst = 1'b1; StallF = 1'b0; BranchTakenE = 1'b0; BranchTargetE = 32'h0;
        TrapReq = 1'b0; Halt = 1'b0; Resume = 1'b0; imem_ready = 1'b0;

        cycle(); cycle();
        chk("rst_pc", PC, 32'h0);
        chk("rst_req", imem_req, 1'b0);
        chk("rst_cnt", FetchCount, 32'h0);
        chk("rst_mis", MisalignF, 1'b0);
        chk("rst_bad", BadAddr, 32'h0);

        rst = 1'b0; imem_ready = 1'b1;
        cycle(); chk("boot_exit_pc", PC, 32'h0); chk("boot_exit_req", imem_req, 1'b1);
        cycle(); chk("seq_pc4", PC, 32'h4);
        cycle(); chk("seq_pc8", PC, 32'h8);
        cycle(); chk("seq_pcC", PC, 32'hC); chk("seq_cnt3", FetchCount, 32'd3);

        imem_ready = 1'b0;
        repeat (3) begin cycle(); chk("notready_hold", PC, 32'hC); end
        imem_ready = 1'b1;
        cycle(); chk("ready_pc10", PC, 32'h10); chk("ready_cnt4", FetchCount, 32'd4);

        StallF = 1'b1; BranchTakenE = 1'b1; BranchTargetE = 32'h40;
        #1 chk("stall_br_flush", FlushD, 1'b1);
        cycle(); chk("stall_br_pc", PC, 32'h40); chk("stall_br_cnt", FetchCount, 32'd4);
        StallF = 1'b0; BranchTakenE = 1'b0;
        #1 chk("noredirect_flush", FlushD, 1'b0);

        TrapReq = 1'b1; BranchTakenE = 1'b1; BranchTargetE = 32'h80;
        #1 chk("trap_br_flush", FlushD, 1'b1);
        cycle(); chk("trap_br_pc", PC, 32'h100); chk("trap_br_cnt", FetchCount, 32'd4);
        TrapReq = 1'b0; BranchTakenE = 1'b0;
        cycle(); chk("after_trap_pc", PC, 32'h104); chk("after_trap_cnt", FetchCount, 32'd5);

        BranchTakenE = 1'b1; BranchTargetE = 32'h42;
        cycle();
        chk("mis_pc", PC, 32'h100); chk("mis_bad", BadAddr, 32'h42);
        chk("mis_pulse", MisalignF, 1'b1); chk("mis_cnt", FetchCount, 32'd5);
        BranchTakenE = 1'b0; imem_ready = 1'b0;
        cycle(); chk("mis_pulse_end", MisalignF, 1'b0); chk("mis_bad_hold", BadAddr, 32'h42);

        Halt = 1'b1;
        cycle(); chk("halt_req", imem_req, 1'b0); chk("halt_pc", PC, 32'h100);
        Halt = 1'b0; imem_ready = 1'b1;
        cycle(); chk("halt_frozen_pc", PC, 32'h100); chk("halt_frozen_cnt", FetchCount, 32'd5);
        BranchTakenE = 1'b1; BranchTargetE = 32'h200;
        cycle(); chk("halt_br_pc", PC, 32'h200); chk("halt_br_req", imem_req, 1'b0);
        BranchTakenE = 1'b0; TrapReq = 1'b1;
        #1 chk("halt_trap_flush", FlushD, 1'b1);
        cycle(); chk("halt_trap_pc", PC, 32'h100); chk("halt_trap_req", imem_req, 1'b1);
        TrapReq = 1'b0;
        cycle(); chk("resumed_pc", PC, 32'h104); chk("resumed_cnt", FetchCount, 32'd6);
        rst = 1'b1;
        cycle(); chk("midrst_pc", PC, 32'h0); chk("midrst_req", imem_req, 1'b0);
        chk("midrst_cnt", FetchCount, 32'h0);
        rst = 1'b0;

        for (int i = 0; i < 3000; i++) begin
            int unsigned sel;
            rst          = ($urandom_range(199) == 0);
            TrapReq      = ($urandom_range(24) == 0);
            BranchTakenE = ($urandom_range(7) == 0);
            Halt         = ($urandom_range(19) == 0);
            Resume       = ($urandom_range(5) == 0);
            StallF       = ($urandom_range(4) == 0);
            imem_ready   = ($urandom_range(9) < 7);
            sel = $urandom_range(9);
            if (sel == 0)
                BranchTargetE = 32'hFFFF_FFFC;
            else if (sel < 3)
                BranchTargetE = $urandom();
            else
                BranchTargetE = {$urandom_range(32'h3FFF_FFFF), 2'b00};
            cycle();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
